// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: command encoding and priority decode for the program counter
package pc_stack_pkg;
  typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_CLR} pc_op_e;

  function automatic pc_op_e pc_decode(input logic clr, input logic ret, input logic call,
                                       input logic load, input logic inc);
    return clr ? OP_CLR : ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD : inc ? OP_INC : OP_HOLD;
  endfunction
endpackage

// File: rtl/lifo_n2t.sv
// lifo_n2t: register-based return-address LIFO with occupancy count
module lifo_n2t #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == CNT_W'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !full && !clr && !do_pop;
  assign cnt_d   = clr ? '0 : do_pop ? cnt_q - CNT_W'(1) : do_push ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // storage needs no reset: it is only read below a valid count
  always_ff @(posedge clk)
    if (do_push) mem_q[cnt_q[AW-1:0]] <= wdata;
  assign rdata = mem_q[cnt_q[AW-1:0] - AW'(1)];
  assign count = cnt_q;
endmodule

// File: rtl/pc_stack_n2t.sv
// pc_stack_n2t: program counter with call/return stack and sticky
// overflow/underflow flags
module pc_stack_n2t
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  input  logic             ret,
  input  logic             call,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] depth_cnt,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow,
  output logic             underflow
);
  pc_op_e op;
  logic [WIDTH-1:0] out_q, out_d, top;
  logic ovf_q, ovf_d, udf_q, udf_d;
  assign op = pc_decode(clr, ret, call, load, inc);
  lifo_n2t #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk(clk), .rst_n(rst_n), .clr(op == OP_CLR),
    .push(op == OP_CALL && !stack_full), .pop(op == OP_RET && !stack_empty),
    .wdata(out_q + WIDTH'(1)), .rdata(top), .count(depth_cnt),
    .full(stack_full), .empty(stack_empty)
  );
  always_comb begin
    out_d = op == OP_CLR ? '0 :
            op == OP_RET ? (stack_empty ? out_q : top) :
            (op == OP_CALL || op == OP_LOAD) ? in :
            op == OP_INC ? out_q + WIDTH'(1) : out_q;
    ovf_d = op == OP_CLR ? 1'b0 : ovf_q | (op == OP_CALL && stack_full);
    udf_d = op == OP_CLR ? 1'b0 : udf_q | (op == OP_RET && stack_empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
endmodule
